// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 8x8 unsigned multiplier sequencer that borrows a shared ALU
// for its additions; one ADD cycle per set multiplier bit, eight SHIFT cycles.
module alu_mul_sequencer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [7:0]  i_multiplicand,
  input  logic [7:0]  i_multiplier,
  input  logic [7:0]  i_alu_result,
  input  logic        i_carry_flag_out,
  output logic        o_alu_select0,
  output logic        o_alu_select1,
  output logic        o_flags_write_enable,
  output logic [7:0]  o_alu_input0,
  output logic [7:0]  o_alu_input1,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_product
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_m;
  logic [7:0]  r_q;
  logic [7:0]  r_phi;
  logic [2:0]  r_cnt;
  logic        r_added;
  logic [15:0] r_product;
  logic        w_c;
  logic [7:0]  w_phi_shifted;
  logic [7:0]  w_q_shifted;

  // The ALU carry is only meaningful right after an ADD; otherwise shift in 0.
  assign w_c           = r_added & i_carry_flag_out;
  assign w_phi_shifted = {w_c, r_phi[7:1]};
  assign w_q_shifted   = {r_phi[0], r_q[7:1]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state         = r_state;
    o_alu_select0        = 1'b0;
    o_alu_select1        = 1'b0;
    o_flags_write_enable = 1'b0;
    o_alu_input0         = 8'h00;
    o_alu_input1         = 8'h00;
    o_busy               = 1'b0;
    o_done               = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next_state = S_LOAD;
      end
      S_LOAD: begin
        o_busy       = 1'b1;
        w_next_state = r_q[0] ? S_ADD : S_SHIFT;
      end
      S_ADD: begin
        o_busy               = 1'b1;
        o_alu_select1        = 1'b1;
        o_flags_write_enable = 1'b1;
        o_alu_input0         = r_phi;
        o_alu_input1         = r_m;
        w_next_state         = S_SHIFT;
      end
      S_SHIFT: begin
        o_busy = 1'b1;
        // Pre-shift Q[1] becomes the next Q[0], so it decides the next step.
        if (r_cnt == 3'd7) w_next_state = S_DONE;
        else               w_next_state = r_q[1] ? S_ADD : S_SHIFT;
      end
      S_DONE: begin
        o_done       = 1'b1;
        w_next_state = i_start ? S_LOAD : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_m       <= 8'h00;
      r_q       <= 8'h00;
      r_phi     <= 8'h00;
      r_cnt     <= 3'd0;
      r_added   <= 1'b0;
      r_product <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_m     <= i_multiplicand;
            r_q     <= i_multiplier;
            r_phi   <= 8'h00;
            r_cnt   <= 3'd0;
            r_added <= 1'b0;
          end
        end
        S_ADD: begin
          r_phi   <= i_alu_result;
          r_added <= 1'b1;
        end
        S_SHIFT: begin
          r_phi   <= w_phi_shifted;
          r_q     <= w_q_shifted;
          r_added <= 1'b0;
          if (r_cnt == 3'd7) begin
            r_product <= {w_phi_shifted, w_q_shifted};
            r_cnt     <= 3'd0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_product = r_product;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Randomised and directed bench for alu_mul_sequencer; models the shared ALU
// with a registered carry and checks product, latency and add count.
module tb_alu_mul_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  mcand;
  logic [7:0]  mplier;
  logic [7:0]  aluResult;
  logic        carryReg;
  logic        sel0;
  logic        sel1;
  logic        fwe;
  logic [7:0]  aluIn0;
  logic [7:0]  aluIn1;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [8:0]  aluSum;

  int errorCount = 0;
  int checkCount = 0;

  alu_mul_sequencer dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_start             (start),
    .i_multiplicand      (mcand),
    .i_multiplier        (mplier),
    .i_alu_result        (aluResult),
    .i_carry_flag_out    (carryReg),
    .o_alu_select0       (sel0),
    .o_alu_select1       (sel1),
    .o_flags_write_enable(fwe),
    .o_alu_input0        (aluIn0),
    .o_alu_input1        (aluIn1),
    .o_busy              (busy),
    .o_done              (done),
    .o_product           (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: combinational adder result, carry flag registered on write enable.
  assign aluSum    = {1'b0, aluIn0} + {1'b0, aluIn1};
  assign aluResult = (sel1 && !sel0) ? aluSum[7:0] : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) carryReg <= 1'b0;
    else if (fwe) carryReg <= aluSum[8];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_product"}, product, 0);
    checkOutput({tag, "_ctrl"}, {sel0, sel1, fwe}, 0);
    checkOutput({tag, "_aluin"}, {aluIn0, aluIn1}, 0);
  endtask

  // Issues one multiply starting at the next rising edge and follows it to Done.
  // With disturb set, Start is re-pulsed with foreign operands while busy.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input bit disturb);
    int k;
    int adds;
    int doneEdge;
    logic [15:0] expProduct;
    k          = $countones(b);
    expProduct = 16'(a) * 16'(b);
    adds       = 0;
    doneEdge   = -1;
    @(negedge clk);
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    @(posedge clk);
    #1;
    checkOutput("busy_after_accept", busy, 1);
    for (int e = 1; e <= 40 && doneEdge < 0; e++) begin
      @(negedge clk);
      if (disturb && e <= 8) begin
        start  = $urandom_range(0, 1);
        mcand  = 8'($urandom);
        mplier = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (fwe) adds++;
      if (done) doneEdge = e;
    end
    checkOutput("latency", doneEdge, 9 + k);
    checkOutput("product", product, expProduct);
    checkOutput("add_cycles", adds, k);
    checkOutput("busy_in_done", busy, 0);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    logic [15:0] held;
    start  = 1'b0;
    mcand  = 8'h00;
    mplier = 8'h00;
    rst_n  = 1'b0;
    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(8'h0D, 8'h0B, 1'b0);
    applyStimulus(8'hFF, 8'hFF, 1'b0);

    // Product must hold while the block idles after DONE.
    held = product;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("product_hold", product, held);
    checkOutput("idle_done", done, 0);

    // Back-to-back: second start lands in the DONE cycle of the first.
    applyStimulus(8'h00, 8'h00, 1'b0);
    applyStimulus(8'h80, 8'h01, 1'b0);

    applyStimulus(8'hA5, 8'h3C, 1'b1);

    // Reset asserted in the middle of an ADD cycle.
    @(negedge clk);
    start  = 1'b1;
    mcand  = 8'h0F;
    mplier = 8'h07;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("in_add_fwe", fwe, 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h0F, 8'h07, 1'b0);

    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (i % 5 == 0) b = 8'hFF;
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      applyStimulus(a, b, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
ALU_MUL_SEQUENCER -- requirements
Module: alu_mul_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: Clock  in  1  sole clock, all state updates on rising edge.
REQ-002 Reset  in  1  asynchronous, active-low; low forces the reset state immediately, independent of Clock.
REQ-003 Start  in  1  request to begin an 8x8 unsigned multiply; sampled on rising Clock.
REQ-004 Multiplicand  in  8  operand M, captured when Start is accepted.
REQ-005 Multiplier  in  8  operand Q, captured when Start is accepted.
REQ-006 ALU_Result  in  8  combinational ALU_OUTPUT of the shared ALU.
REQ-007 CarryFlagOut  in  1  registered carry flag from the shared ALU.
REQ-008 ALU_Select0  out  1  ALU op select bit 0 (0 = add when ALU_Select1 = 1).
REQ-009 ALU_Select1  out  1  ALU op select bit 1 (1 = adder path).
REQ-010 Flags_Write_Enable  out  1  ALU flag-register write enable.
REQ-011 ALU_Input0  out  8  ALU operand 0.
REQ-012 ALU_Input1  out  8  ALU operand 1.
REQ-013 Busy  out  1  high in every state except IDLE and DONE.
REQ-014 Done  out  1  high for exactly the one cycle spent in DONE.
REQ-015 Product  out  16  result register; holds its value until the next accepted Start.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, ADD, SHIFT and DONE, with a 3-bit iteration counter Cnt and a 1-bit Added flag.
REQ-017 IDLE or DONE with Start=1 SHALL go to LOAD, capturing M, Q, P_hi=0, Cnt=0 and Added=0; IDLE with Start=0 SHALL stay in IDLE; DONE with Start=0 SHALL go to IDLE.
REQ-018 Start SHALL be ignored in LOAD, ADD and SHIFT; no operand or state change occurs.
REQ-019 LOAD SHALL go to ADD if Q[0]=1, otherwise to SHIFT.
REQ-020 ADD SHALL drive ALU_Select1=1, ALU_Select0=0, ALU_Input0=P_hi, ALU_Input1=M and Flags_Write_Enable=1; on exit it captures P_hi<=ALU_Result, sets Added<=1 and goes to SHIFT.
REQ-021 SHIFT SHALL compute C = Added ? CarryFlagOut : 0, then update {P_hi,Q} <= {C,P_hi,Q}>>1 and Added<=0; it drives no ALU write.
REQ-022 SHIFT with Cnt=7 SHALL load Product<={P_hi,Q} (post-shift values), reset Cnt to 0 and go to DONE.
REQ-023 SHIFT with Cnt<7 SHALL increment Cnt, then go to ADD if the pre-shift Q[1]=1, otherwise to SHIFT.
REQ-024 In every state except ADD, ALU_Select0, ALU_Select1, Flags_Write_Enable, ALU_Input0 and ALU_Input1 SHALL all be 0.
REQ-025 Latency SHALL be fixed by popcount: with k = popcount(Multiplier), Done SHALL be high in the cycle following edge 9+k, counted from the edge that accepts Start (edge 0).
REQ-026 Product SHALL equal Multiplicand*Multiplier exactly, with no truncation, for all 65536 input pairs.
REQ-027 Start=1 in DONE SHALL be accepted back-to-back with no idle cycle; Done still pulses for its one cycle.

Reset
REQ-028 Reset low SHALL, at any time including mid-operation, force IDLE; Cnt, Added, P_hi, captured operands, Product, Busy, Done and all ALU control outputs go to 0.
REQ-029 After Reset deasserts, the first Start seen on a rising Clock SHALL be accepted normally.

Verification (bench wires the team's ALU with a registered carry)
REQ-030 0x0D*0x0B, k=3: Done at edge 12, Product=0x008F, exactly 3 cycles with Flags_Write_Enable=1.
REQ-031 0xFF*0xFF, k=8: Done at edge 17, Product=0xFE01; confirms carry propagates through P_hi.
REQ-032 0x00*0x00, then 0x80*0x01 started in the DONE cycle: first Product=0x0000 at edge 9; second is accepted with no idle cycle and gives Product=0x0080 after 10 further edges.
REQ-033 Start pulses with new operands while Busy: these are ignored, and the result matches the original operands.
REQ-034 Reset pulsed low mid-ADD: all outputs are 0 immediately, with no Clock edge needed; the next Start gives the correct result and latency.
